// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated memory controller.
// Holds the row-buffer cost model used by the row scheduler.
package simmem_pkg;

   // Address and id geometry
   localparam int unsigned AxAddrWidth   = 20;
   localparam int unsigned RowIdWidth    = 10;
   localparam int unsigned WriteIidWidth = 4;
   localparam int unsigned ReadIidWidth  = 4;

   typedef logic [WriteIidWidth-1:0] write_iid_t;
   typedef logic [ReadIidWidth-1:0]  read_iid_t;
   typedef logic [RowIdWidth-1:0]    row_id_t;

   // Which response bank a completion belongs to. WRSP_BANK is the zero encoding,
   // so an idle completion port reads as all-zero after reset.
   typedef enum logic {
      WRSP_BANK  = 1'b0,
      RDATA_BANK = 1'b1
   } rsp_bank_type_e;

   // Default DRAM timing, in cycles
   localparam int unsigned DefRowHitCost     = 10;
   localparam int unsigned DefPrechargeCost  = 50;
   localparam int unsigned DefActivationCost = 45;
   localparam int unsigned RowAccessCostMax  =
      DefPrechargeCost + DefActivationCost + DefRowHitCost;

   typedef enum logic [1:0] {
      SCHED_IDLE  = 2'd0,
      SCHED_SERVE = 2'd1,
      SCHED_DONE  = 2'd2
   } row_sched_state_e;

   // Cost of one access given the current row-buffer state.
   // Hit: just the column access. Closed: activate first. Other row open: precharge too.
   // The timing values are passed in so a scheduler with overridden parameters stays consistent.
   function automatic int unsigned get_row_access_cost(
      input logic        open,
      input row_id_t     open_row,
      input row_id_t     row,
      input int unsigned hit_cost,
      input int unsigned pre_cost,
      input int unsigned act_cost
   );
      if (open && (row == open_row)) begin
         return hit_cost;
      end else if (!open) begin
         return act_cost + hit_cost;
      end else begin
         return pre_cost + act_cost + hit_cost;
      end
   endfunction

endpackage

// File: rtl/simmem_row_scheduler.sv
// Single-bank row-buffer scheduler: arbitrates one write and one read requester,
// tracks the open row (open-page policy) and charges each access its DRAM cost
// as a countdown before reporting completion with the internal id.
//
// Handshakes: a request transfers on a cycle where valid and ready are both high;
// a requester seeing valid without ready keeps valid and payload stable. The
// completion port follows the same rule with done_valid_o / done_ready_i.
module simmem_row_scheduler
   import simmem_pkg::*;
#(
   parameter int unsigned RowHitCost     = DefRowHitCost,
   parameter int unsigned PrechargeCost  = DefPrechargeCost,
   parameter int unsigned ActivationCost = DefActivationCost
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   waddr_valid_i,
   output logic                   waddr_ready_o,
   input  logic [AxAddrWidth-1:0] waddr_addr_i,
   input  write_iid_t             waddr_iid_i,
   input  logic                   raddr_valid_i,
   output logic                   raddr_ready_o,
   input  logic [AxAddrWidth-1:0] raddr_addr_i,
   input  read_iid_t              raddr_iid_i,
   output logic                   done_valid_o,
   input  logic                   done_ready_i,
   output rsp_bank_type_e         done_type_o,
   output write_iid_t             done_wiid_o,
   output read_iid_t              done_riid_o,
   output logic                   row_open_o,
   output row_id_t                open_row_o,
   output row_sched_state_e       dbg_state_o
);

   localparam int unsigned CntW = $clog2(PrechargeCost + ActivationCost + RowHitCost + 1);

   row_sched_state_e state_q;
   logic [CntW-1:0]  cnt_q;
   logic             row_open_q;
   row_id_t          open_row_q;
   rsp_bank_type_e   last_grant_q;
   rsp_bank_type_e   done_type_q;
   write_iid_t       done_wiid_q;
   read_iid_t        done_riid_q;

   row_id_t         wrow, rrow;
   logic            whit, rhit;
   logic [CntW-1:0] wcost, rcost;
   logic            grant_w, grant_r;

   // Only the row bits of the address matter to this bank model.
   logic addr_lsb_unused;
   assign addr_lsb_unused = ^{waddr_addr_i[AxAddrWidth-RowIdWidth-1:0],
                              raddr_addr_i[AxAddrWidth-RowIdWidth-1:0]};

   // Row decode, cost lookup and arbitration; grants only in IDLE, at most one at a time.
   always_comb begin
      wrow    = waddr_addr_i[AxAddrWidth-1 -: RowIdWidth];
      rrow    = raddr_addr_i[AxAddrWidth-1 -: RowIdWidth];
      whit    = row_open_q && (wrow == open_row_q);
      rhit    = row_open_q && (rrow == open_row_q);
      wcost   = CntW'(get_row_access_cost(row_open_q, open_row_q, wrow,
                                          RowHitCost, PrechargeCost, ActivationCost));
      rcost   = CntW'(get_row_access_cost(row_open_q, open_row_q, rrow,
                                          RowHitCost, PrechargeCost, ActivationCost));
      grant_w = 1'b0;
      grant_r = 1'b0;
      // rst_ni gating keeps ready low while reset is held, even if a requester is valid.
      if ((state_q == SCHED_IDLE) && rst_ni) begin
         if (waddr_valid_i && raddr_valid_i) begin
            // Prefer the row hitter; on a tie alternate away from the last winner.
            if (whit != rhit) begin
               grant_w = whit;
            end else begin
               grant_w = (last_grant_q == RDATA_BANK);
            end
            grant_r = !grant_w;
         end else begin
            grant_w = waddr_valid_i;
            grant_r = raddr_valid_i;
         end
      end
   end

   // Scheduler FSM: accept, count down the access cost, hold the completion until taken.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= SCHED_IDLE;
         cnt_q        <= '0;
         row_open_q   <= 1'b0;
         open_row_q   <= '0;
         last_grant_q <= RDATA_BANK;
         done_type_q  <= WRSP_BANK;
         done_wiid_q  <= '0;
         done_riid_q  <= '0;
      end else begin
         case (state_q)
            SCHED_IDLE: begin
               if (grant_w) begin
                  state_q      <= SCHED_SERVE;
                  cnt_q        <= wcost - 1'b1;
                  open_row_q   <= wrow;
                  row_open_q   <= 1'b1;
                  last_grant_q <= WRSP_BANK;
                  done_type_q  <= WRSP_BANK;
                  done_wiid_q  <= waddr_iid_i;
                  done_riid_q  <= '0;
               end else if (grant_r) begin
                  state_q      <= SCHED_SERVE;
                  cnt_q        <= rcost - 1'b1;
                  open_row_q   <= rrow;
                  row_open_q   <= 1'b1;
                  last_grant_q <= RDATA_BANK;
                  done_type_q  <= RDATA_BANK;
                  done_wiid_q  <= '0;
                  done_riid_q  <= raddr_iid_i;
               end
            end
            SCHED_SERVE: begin
               // Leave when the count is about to reach zero, so the accept cycle plus
               // cost-1 SERVE cycles put done_valid_o high exactly cost cycles after accept.
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_q <= SCHED_DONE;
               end
            end
            SCHED_DONE: begin
               if (done_ready_i) begin
                  state_q <= SCHED_IDLE;
               end
            end
            default: begin
               state_q <= SCHED_IDLE;
            end
         endcase
      end
   end

   assign waddr_ready_o = grant_w;
   assign raddr_ready_o = grant_r;
   assign done_valid_o  = (state_q == SCHED_DONE);
   assign done_type_o   = done_type_q;
   assign done_wiid_o   = done_wiid_q;
   assign done_riid_o   = done_riid_q;
   assign row_open_o    = row_open_q;
   assign open_row_o    = open_row_q;
   assign dbg_state_o   = state_q;

endmodule
